// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and sequencing controller for the 5-stage
// IF/ID/EX/MEM/WB pipeline.
//
// Keeps a shadow copy of the EX, MEM and WB instructions (destination,
// write enable, instruction class and, for forwarding, the EX sources).
// From these it derives the per-stage stall/flush controls, the EX operand
// forwarding selects, load-use bubbles, branch-redirect flushes and the
// start/wait sequencing of the multi-cycle MUL/DIV unit in EX.
//
// Build option: PCTRL_FWD_EN
//   defined   : EX operands are forwarded from EX/MEM and MEM/WB; only a
//               load-use dependency stalls ID.
//   undefined : forwarding selects are tied to 00 and any read-after-write
//               dependency on the EX or MEM instruction stalls ID until it
//               has reached WB (regfile write-through covers WB->ID).
//
// Ports
//   clk, arst_n              clock, asynchronous active-low reset
//   id_valid                 ID holds a valid instruction
//   id_rs1_addr/id_rs2_addr  ID source registers
//   id_rs1_used/id_rs2_used  ID actually reads rs1/rs2
//   id_rd_addr, id_wb_en     ID destination register and its write enable
//   id_is_load, id_is_mdu    ID instruction class
//   ex_branch_taken          EX resolved a taken branch/jump
//   mdu_done                 MUL/DIV result valid (1-cycle pulse)
//   if_stall, id_stall       hold PC + IF/ID, hold ID/EX source
//   if_flush, id_flush       IF/ID, ID/EX load a bubble
//   ex_stall                 hold EX/MEM source while MUL/DIV is busy
//   mdu_start                1-cycle start pulse to MUL/DIV
//   fwd_a_sel, fwd_b_sel     EX operand source: 00 regfile, 01 EX/MEM,
//                            10 MEM/WB
//   dbg_state                current controller state (debug observation)

module pipeline_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int RST_FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_wb_en,
    input  logic                  id_is_load,
    input  logic                  id_is_mdu,
    input  logic                  ex_branch_taken,
    input  logic                  mdu_done,
    output logic                  if_stall,
    output logic                  id_stall,
    output logic                  if_flush,
    output logic                  id_flush,
    output logic                  ex_stall,
    output logic                  mdu_start,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [1:0]            dbg_state
);

    // DATA_WIDTH has no datapath in this block; it only takes part in this
    // constant so the parameter can stay in the common core interface.
    localparam int CNT_W = (DATA_WIDTH > 0) ? 4 : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST_FLUSH = 2'd0,
        ST_RUN       = 2'd1,
        ST_MDU_BUSY  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // EX shadow
    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_wb_en_q, ex_wb_en_d;
    logic                  ex_is_load_q, ex_is_load_d;
    logic                  ex_is_mdu_q, ex_is_mdu_d;
`ifdef PCTRL_FWD_EN
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic                  ex_rs1_used_q, ex_rs1_used_d;
    logic                  ex_rs2_used_q, ex_rs2_used_d;
`endif

    // MEM shadow
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_wb_en_q, mem_wb_en_d;

`ifdef PCTRL_FWD_EN
    // WB shadow is only a forwarding source; without forwarding the regfile
    // write-through already serves WB->ID.
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_wb_en_q, wb_wb_en_d;
`endif

    // True when a shadow instruction writes a register that a consumer
    // actually reads. x0 is never a dependency.
    function automatic logic writes_src(input logic                  valid,
                                        input logic                  wb_en,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] src,
                                        input logic                  used);
        return valid && wb_en && (rd != '0) && (rd == src) && used;
    endfunction

    logic id_dep_ex;
    logic hazard;
    logic mdu_in_ex;

    assign id_dep_ex = id_valid &&
        (writes_src(ex_valid_q, ex_wb_en_q, ex_rd_q, id_rs1_addr, id_rs1_used) ||
         writes_src(ex_valid_q, ex_wb_en_q, ex_rd_q, id_rs2_addr, id_rs2_used));

`ifdef PCTRL_FWD_EN
    assign hazard = id_dep_ex && ex_is_load_q;
`else
    logic id_dep_mem;
    assign id_dep_mem = id_valid &&
        (writes_src(mem_valid_q, mem_wb_en_q, mem_rd_q, id_rs1_addr, id_rs1_used) ||
         writes_src(mem_valid_q, mem_wb_en_q, mem_rd_q, id_rs2_addr, id_rs2_used));
    assign hazard = id_dep_ex || id_dep_mem;
`endif

    assign mdu_in_ex = ex_valid_q && ex_is_mdu_q;
    assign dbg_state = state_q;

    // MUL/DIV handshake: mdu_start is a single-cycle request issued while
    // the MUL/DIV instruction sits in EX; the unit answers with a
    // single-cycle mdu_done once the result is valid. Between the two the
    // front end and EX hold, and MEM receives bubbles. On the done cycle
    // EX releases and the normal hazard rules apply to the ID instruction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_stall  = 1'b0;
        mdu_start = 1'b0;

        unique case (state_q)
            ST_RST_FLUSH: begin
                if_flush = 1'b1;
                id_flush = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // Redirect wins over any stall; the wrong-path ID
                    // instruction becomes the EX bubble.
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                end else if (mdu_in_ex) begin
                    // Start cycle already holds EX so the MUL/DIV
                    // instruction stays put while the unit works.
                    mdu_start = 1'b1;
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    state_d   = ST_MDU_BUSY;
                end else if (hazard) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    id_flush = 1'b1;
                end
            end
            ST_MDU_BUSY: begin
                if (mdu_done) begin
                    state_d = ST_RUN;
                    if (hazard) begin
                        if_stall = 1'b1;
                        id_stall = 1'b1;
                        id_flush = 1'b1;
                    end
                end else begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_stall = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    // Forwarding selects: the younger producer (EX/MEM) has priority.
`ifdef PCTRL_FWD_EN
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid_q) begin
            if (writes_src(mem_valid_q, mem_wb_en_q, mem_rd_q, ex_rs1_q, ex_rs1_used_q))
                fwd_a_sel = 2'b01;
            else if (writes_src(wb_valid_q, wb_wb_en_q, wb_rd_q, ex_rs1_q, ex_rs1_used_q))
                fwd_a_sel = 2'b10;
            if (writes_src(mem_valid_q, mem_wb_en_q, mem_rd_q, ex_rs2_q, ex_rs2_used_q))
                fwd_b_sel = 2'b01;
            else if (writes_src(wb_valid_q, wb_wb_en_q, wb_rd_q, ex_rs2_q, ex_rs2_used_q))
                fwd_b_sel = 2'b10;
        end
    end
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // Shadow advance mirrors what the stage registers do under the same
    // stall/flush controls. Invalidated entries are cleared entirely so no
    // stale field can produce a match.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_wb_en_d   = ex_wb_en_q;
        ex_is_load_d = ex_is_load_q;
        ex_is_mdu_d  = ex_is_mdu_q;
`ifdef PCTRL_FWD_EN
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rs1_used_d = ex_rs1_used_q;
        ex_rs2_used_d = ex_rs2_used_q;
`endif
        if (!ex_stall) begin
            if (id_valid && !id_stall && !id_flush) begin
                ex_valid_d   = 1'b1;
                ex_rd_d      = id_rd_addr;
                ex_wb_en_d   = id_wb_en;
                ex_is_load_d = id_is_load;
                ex_is_mdu_d  = id_is_mdu;
`ifdef PCTRL_FWD_EN
                ex_rs1_d      = id_rs1_addr;
                ex_rs2_d      = id_rs2_addr;
                ex_rs1_used_d = id_rs1_used;
                ex_rs2_used_d = id_rs2_used;
`endif
            end else begin
                ex_valid_d   = 1'b0;
                ex_rd_d      = '0;
                ex_wb_en_d   = 1'b0;
                ex_is_load_d = 1'b0;
                ex_is_mdu_d  = 1'b0;
`ifdef PCTRL_FWD_EN
                ex_rs1_d      = '0;
                ex_rs2_d      = '0;
                ex_rs1_used_d = 1'b0;
                ex_rs2_used_d = 1'b0;
`endif
            end
        end

        if (ex_stall) begin
            mem_valid_d = 1'b0;
            mem_rd_d    = '0;
            mem_wb_en_d = 1'b0;
        end else begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_wb_en_d = ex_wb_en_q;
        end

`ifdef PCTRL_FWD_EN
        wb_valid_d = mem_valid_q;
        wb_rd_d    = mem_rd_q;
        wb_wb_en_d = mem_wb_en_q;
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_RST_FLUSH;
            cnt_q        <= '0;
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_wb_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_is_mdu_q  <= 1'b0;
`ifdef PCTRL_FWD_EN
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_wb_en_q    <= 1'b0;
`endif
            mem_valid_q  <= 1'b0;
            mem_rd_q     <= '0;
            mem_wb_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_wb_en_q   <= ex_wb_en_d;
            ex_is_load_q <= ex_is_load_d;
            ex_is_mdu_q  <= ex_is_mdu_d;
`ifdef PCTRL_FWD_EN
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rs1_used_q <= ex_rs1_used_d;
            ex_rs2_used_q <= ex_rs2_used_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_wb_en_q    <= wb_wb_en_d;
`endif
            mem_valid_q  <= mem_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_wb_en_q  <= mem_wb_en_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed test-plan sequences followed by random
// instruction streams, every cycle checked against an instruction-level
// pipeline model. Output vector layout used throughout:
// {if_stall, id_stall, if_flush, id_flush, ex_stall, mdu_start,
//  fwd_a_sel[1:0], fwd_b_sel[1:0]}

module tb_pipeline_ctrl;

    localparam int FLUSH_N = 2;

    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_RST    = 10'b0011000000;
    localparam logic [9:0] V_LUSE   = 10'b1101000000;
    localparam logic [9:0] V_MSTART = 10'b1100110000;
    localparam logic [9:0] V_MBUSY  = 10'b1100100000;
    localparam logic [9:0] V_FA_MEM = 10'b0000000100;
    localparam logic [9:0] V_FA_WB  = 10'b0000001000;
    localparam logic [9:0] V_FAB_WB = 10'b0000001010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    logic       id_valid, id_rs1_used, id_rs2_used, id_wb_en;
    logic       id_is_load, id_is_mdu, ex_branch_taken, mdu_done;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       if_stall, id_stall, if_flush, id_flush, ex_stall, mdu_start;
    logic [1:0] fwd_a_sel, fwd_b_sel, dbg_state;
    logic [9:0] obs_vec;

    assign obs_vec = {if_stall, id_stall, if_flush, id_flush, ex_stall,
                      mdu_start, fwd_a_sel, fwd_b_sel};

    pipeline_ctrl #(
        .DATA_WIDTH(32), .REG_ADDR_W(5), .RST_FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
        .if_stall(if_stall), .id_stall(id_stall), .if_flush(if_flush),
        .id_flush(id_flush), .ex_stall(ex_stall), .mdu_start(mdu_start),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v; bit wb; bit ld; bit mdu;
        int rd; int rs1; int rs2; bit u1; bit u2;
    } ins_t;

    ins_t       m_ex, m_mem, m_wb;
    int         flush_left;
    bit         busy;
    int         busy_cnt;
    int         mdu_lat;
    logic [9:0] e_vec;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic ins_t bubble();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic ins_t id_ins();
        ins_t n;
        n.v = 1'b1; n.wb = id_wb_en; n.ld = id_is_load; n.mdu = id_is_mdu;
        n.rd = int'(id_rd_addr); n.rs1 = int'(id_rs1_addr); n.rs2 = int'(id_rs2_addr);
        n.u1 = id_rs1_used; n.u2 = id_rs2_used;
        return n;
    endfunction

    // Does instruction e produce the value register src that a consumer reads?
    function automatic bit writes(input ins_t e, input int src, input bit used);
        return e.v && e.wb && (e.rd != 0) && (e.rd == src) && used;
    endfunction

    task automatic model_reset();
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        flush_left = FLUSH_N;
        busy = 1'b0;
        busy_cnt = 0;
        mdu_lat = 1;
    endtask

    task automatic compute_expected();
        bit hz, dex;
        logic [1:0] fa, fb;
        e_vec = '0;
        dex = id_valid && (writes(m_ex, int'(id_rs1_addr), id_rs1_used) ||
                           writes(m_ex, int'(id_rs2_addr), id_rs2_used));
`ifdef PCTRL_FWD_EN
        hz = dex && m_ex.ld;
`else
        begin
            bit dmem;
            dmem = id_valid && (writes(m_mem, int'(id_rs1_addr), id_rs1_used) ||
                                writes(m_mem, int'(id_rs2_addr), id_rs2_used));
            hz = dex || dmem;
        end
`endif
        if (flush_left > 0) begin
            e_vec[7:6] = 2'b11;
        end else if (busy) begin
            if (!mdu_done) begin
                e_vec[9] = 1'b1; e_vec[8] = 1'b1; e_vec[5] = 1'b1;
            end else if (hz) begin
                e_vec[9] = 1'b1; e_vec[8] = 1'b1; e_vec[6] = 1'b1;
            end
        end else if (ex_branch_taken) begin
            e_vec[7:6] = 2'b11;
        end else if (m_ex.v && m_ex.mdu) begin
            e_vec[9] = 1'b1; e_vec[8] = 1'b1; e_vec[5] = 1'b1; e_vec[4] = 1'b1;
        end else if (hz) begin
            e_vec[9] = 1'b1; e_vec[8] = 1'b1; e_vec[6] = 1'b1;
        end
        fa = 2'b00;
        fb = 2'b00;
`ifdef PCTRL_FWD_EN
        if (m_ex.v) begin
            if (writes(m_mem, m_ex.rs1, m_ex.u1)) fa = 2'b01;
            else if (writes(m_wb, m_ex.rs1, m_ex.u1)) fa = 2'b10;
            if (writes(m_mem, m_ex.rs2, m_ex.u2)) fb = 2'b01;
            else if (writes(m_wb, m_ex.rs2, m_ex.u2)) fb = 2'b10;
        end
`endif
        e_vec[3:2] = fa;
        e_vec[1:0] = fb;
    endtask

    task automatic model_advance();
        m_wb = m_mem;
        m_mem = e_vec[5] ? bubble() : m_ex;
        if (!e_vec[5])
            m_ex = (e_vec[6] || e_vec[8] || !id_valid) ? bubble() : id_ins();
        if (flush_left > 0) flush_left--;
        if (e_vec[4]) begin
            busy = 1'b1;
            busy_cnt = 0;
            mdu_lat = $urandom_range(1, 5);
        end else if (busy && mdu_done) begin
            busy = 1'b0;
        end else if (busy) begin
            busy_cnt++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (posedge + 1). Check at the falling edge,
    // advance the model, and return at the next drive point.
    task automatic cycle(input string tag, input bit has_plan, input logic [9:0] plan);
        compute_expected();
        @(negedge clk);
        check({tag, "/model"}, obs_vec, e_vec);
        if (has_plan) check({tag, "/plan"}, obs_vec, plan);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_nop();
        id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_addr = '0;
        id_wb_en = 1'b0; id_is_load = 1'b0; id_is_mdu = 1'b0;
        ex_branch_taken = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic drive_id(input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit wb, input bit ld, input bit mdu);
        id_valid = 1'b1;
        id_rs1_addr = 5'(rs1); id_rs1_used = u1;
        id_rs2_addr = 5'(rs2); id_rs2_used = u2;
        id_rd_addr = 5'(rd); id_wb_en = wb;
        id_is_load = ld; id_is_mdu = mdu;
    endtask

    task automatic nops(input int n);
        set_nop();
        for (int i = 0; i < n; i++) cycle("nop", 1'b0, V_IDLE);
    endtask

    task automatic do_reset();
        set_nop();
        arst_n = 1'b0;
        #1;
        check("reset_async", obs_vec, V_RST);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", obs_vec, V_RST);
        arst_n = 1'b1;
    endtask

    task automatic release_seq();
        set_nop();
        cycle("rel_flush0", 1'b1, V_RST);
        cycle("rel_flush1", 1'b1, V_RST);
        cycle("rel_run", 1'b1, V_IDLE);
    endtask

    task automatic drive_random();
        int kind;
        id_valid    = ($urandom_range(0, 9) != 0);
        id_rs1_addr = 5'($urandom_range(0, 7));
        id_rs2_addr = 5'($urandom_range(0, 7));
        id_rs1_used = 1'($urandom_range(0, 1));
        id_rs2_used = 1'($urandom_range(0, 1));
        id_rd_addr  = 5'($urandom_range(0, 7));
        id_wb_en    = ($urandom_range(0, 3) != 0);
        kind        = $urandom_range(0, 19);
        id_is_load  = (kind < 5);
        id_is_mdu   = (kind == 5);
        ex_branch_taken = (!busy && flush_left == 0 && $urandom_range(0, 9) == 0);
        if (busy) mdu_done = (busy_cnt + 1 == mdu_lat);
        else      mdu_done = ($urandom_range(0, 19) == 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        set_nop();
        model_reset();
        #2;
        do_reset();
        release_seq();

`ifdef PCTRL_FWD_EN
        // back-to-back dependency: EX/MEM forward
        nops(3);
        drive_id(1, 1, 2, 1, 5, 1, 0, 0); cycle("add5", 1'b1, V_IDLE);
        drive_id(5, 1, 1, 1, 6, 1, 0, 0); cycle("add6_id", 1'b1, V_IDLE);
        set_nop();                        cycle("fwd_mem", 1'b1, V_FA_MEM);
        // one nop in between: MEM/WB forward
        nops(3);
        drive_id(1, 1, 2, 1, 5, 1, 0, 0); cycle("add5b", 1'b1, V_IDLE);
        set_nop();                        cycle("gap", 1'b1, V_IDLE);
        drive_id(5, 1, 1, 1, 6, 1, 0, 0); cycle("add6b_id", 1'b1, V_IDLE);
        set_nop();                        cycle("fwd_wb", 1'b1, V_FA_WB);
        // load-use: one bubble then forward from WB on both operands
        nops(3);
        drive_id(1, 1, 0, 0, 7, 1, 1, 0); cycle("lw7", 1'b1, V_IDLE);
        drive_id(7, 1, 7, 1, 8, 1, 0, 0); cycle("luse", 1'b1, V_LUSE);
                                          cycle("luse_release", 1'b1, V_IDLE);
        set_nop();                        cycle("luse_fwd", 1'b1, V_FAB_WB);
`else
        // RAW without forwarding: two stall cycles
        nops(3);
        drive_id(1, 1, 2, 1, 5, 1, 0, 0); cycle("add5", 1'b1, V_IDLE);
        drive_id(5, 1, 2, 1, 6, 1, 0, 0); cycle("raw_ex", 1'b1, V_LUSE);
                                          cycle("raw_mem", 1'b1, V_LUSE);
                                          cycle("raw_wb", 1'b1, V_IDLE);
        set_nop();                        cycle("raw_done", 1'b1, V_IDLE);
        // writes to x0 never stall
        nops(3);
        drive_id(1, 1, 2, 1, 0, 1, 0, 0); cycle("add_x0", 1'b1, V_IDLE);
        drive_id(0, 1, 0, 1, 6, 1, 0, 0); cycle("use_x0", 1'b1, V_IDLE);
        set_nop();                        cycle("use_x0_ex", 1'b1, V_IDLE);
`endif

        // branch overrides load-use stall
        nops(3);
        drive_id(1, 1, 0, 0, 7, 1, 1, 0); cycle("br_lw7", 1'b1, V_IDLE);
        drive_id(7, 1, 7, 1, 8, 1, 0, 0);
        ex_branch_taken = 1'b1;           cycle("br_luse", 1'b1, V_RST);
        set_nop();                        cycle("br_after", 1'b1, V_IDLE);

        // MUL/DIV: done arrives 4 cycles after start
        nops(3);
        drive_id(0, 0, 0, 0, 9, 1, 0, 1); cycle("mul_id", 1'b1, V_IDLE);
        set_nop();                        cycle("mdu_start", 1'b1, V_MSTART);
        for (int i = 0; i < 3; i++)       cycle("mdu_busy", 1'b1, V_MBUSY);
        mdu_done = 1'b1;                  cycle("mdu_done", 1'b1, V_IDLE);
        mdu_done = 1'b0;                  cycle("mdu_after", 1'b1, V_IDLE);

        // reset in the middle of a MUL/DIV operation
        nops(3);
        drive_id(0, 0, 0, 0, 9, 1, 0, 1); cycle("mul2_id", 1'b1, V_IDLE);
        set_nop();                        cycle("mdu2_start", 1'b1, V_MSTART);
                                          cycle("mdu2_busy", 1'b1, V_MBUSY);
        do_reset();
        release_seq();

        // random instruction streams, with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                do_reset();
                release_seq();
            end
            drive_random();
            cycle("rand", 1'b0, V_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB core pipeline.
- Tracks its own shadow copy of destination and source registers for EX/MEM/WB.
- Generates per-stage stall/flush, EX operand-forwarding selects, load-use bubbles, branch-redirect flushes and the start/wait handshake for a multi-cycle MUL/DIV unit in EX.
- Sits beside the stage instances in core; all stage pipeline registers obey its stall/flush outputs.

Parameters:
DATA_WIDTH, 32, datapath width (passed through for consistency; no internal use beyond lint)
REG_ADDR_W, 5, register address width
RST_FLUSH_CYCLES, 2, cycles fetch is held flushed after reset release (1..15)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs1_addr  in  REG_ADDR_W  ID source 1
id_rs2_addr  in  REG_ADDR_W  ID source 2
id_rs1_used  in  1  ID reads rs1
id_rs2_used  in  1  ID reads rs2
id_rd_addr  in  REG_ADDR_W  ID destination
id_wb_en  in  1  ID writes rd
id_is_load  in  1  ID is a load
id_is_mdu  in  1  ID is MUL/DIV
ex_branch_taken  in  1  EX resolved taken branch/jump (redirect)
mdu_done  in  1  MUL/DIV result valid (1-cycle pulse)
if_stall  out  1  hold PC and IF/ID
id_stall  out  1  hold ID/EX source
if_flush  out  1  IF/ID register loads bubble
id_flush  out  1  ID/EX register loads bubble
ex_stall  out  1  hold EX/MEM source (MDU busy)
mdu_start  out  1  1-cycle start pulse to MUL/DIV
fwd_a_sel  out  2  EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  EX operand B: same encoding

Behaviour:
- Clock `clk`; reset `arst_n` is asynchronous, active-low.
- Reset values:
  - if_flush=1, id_flush=1.
  - All other outputs 0.
  - Shadow stages invalid.
  - FSM=RST_FLUSH.
  - Flush counter=0.
- Shadow entries: sh_ex{valid,rd,wb_en,is_load,is_mdu,rs1,rs2}, sh_mem{valid,rd,wb_en,is_load}, sh_wb{valid,rd,wb_en}.
- Shadow advance, each cycle:
  - sh_wb<=sh_mem.
  - sh_mem<=sh_ex, or invalid if ex_stall.
  - sh_ex<=ID fields when id_valid and not id_stall/id_flush; invalid on id_flush/bubble; held on ex_stall.
- Any hazard match requires valid && wb_en && rd!=0 && rd==src && src_used. x0 never hazards.
- Load-use: sh_ex.is_load matches an ID source.
  - if_stall=id_stall=1, id_flush=1 (bubble into EX) for exactly 1 cycle.
- Forwarding, combinational on sh_ex.rs1/rs2: MEM match -> 01; else WB match -> 10; else 00. MEM has priority.
- Regfile write-through is assumed by the design: WB->ID never stalls.
- Branch: ex_branch_taken=1 -> if_flush=1, id_flush=1 that cycle.
  - Overrides load-use stall: stalls deasserted.
  - The sh_ex entry being flushed is invalidated.
- FSM states:
  - RST_FLUSH: if_flush=id_flush=1, if_stall=0. Counter increments to RST_FLUSH_CYCLES, then -> RUN.
  - RUN: normal hazard logic. If sh_ex.valid && sh_ex.is_mdu && no flush: mdu_start=1 for one cycle, -> MDU_BUSY.
  - MDU_BUSY: if_stall=id_stall=ex_stall=1; MEM receives bubbles. On mdu_done: ex_stall drops that cycle, EX entry advances to MEM, -> RUN.
- mdu_done in RUN is ignored. ex_branch_taken in MDU_BUSY cannot occur and is ignored.
- Simultaneous load-use and mdu start: MDU entry is in EX, so no load in EX; no conflict.
- Reset asserted mid-MDU: immediate return to RST_FLUSH, shadows cleared, mdu_start=0.

Optional Feature:
PCTRL_FWD_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined:
  - fwd_a_sel=fwd_b_sel=00 constant.
  - Any RAW match against sh_ex or sh_mem stalls ID: if_stall=id_stall=1, id_flush=1 until cleared.
  - Branch flush still overrides.

Test Plan:
- Reset release, RST_FLUSH_CYCLES=2 -> if_flush=id_flush=1 for 2 cycles after arst_n rises, then 0; all other outputs 0.
- add x5 then add x6,x5,x1 back-to-back (FWD_EN) -> fwd_a_sel=01 when second add in EX; no stall. With one nop between -> fwd_a_sel=10.
- lw x7 then add x8,x7,x7 -> one cycle if_stall=id_stall=id_flush=1; next cycle fwd_a_sel=fwd_b_sel=10.
- lw x7 in EX + use in ID + ex_branch_taken=1 same cycle -> if_flush=id_flush=1, if_stall=0.
- mul in EX, mdu_done 4 cycles after mdu_start -> mdu_start single pulse; ex_stall/if_stall=1 for 4 cycles; RUN on done cycle. arst_n low at cycle 2 -> all outputs to reset values immediately.
- No PCTRL_FWD_EN, add x5 then sub x6,x5,x2 -> 2 stall cycles, fwd sels remain 00. Writes to x0 never stall.
